// File: rtl/wb_trace_pkg.sv
// Shared types and default sizes for the writeback trace buffer.
// Pure declarations, no logic and no latency.
// No flow control lives here.
package wb_trace_pkg;

  localparam int TRACE_NUM_CH = 2;
  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_ADDR_W = 5;
  localparam int TRACE_DEPTH  = 16;
  localparam int TRACE_CYC_W  = 16;
  localparam int TRACE_CH_W   = (TRACE_NUM_CH > 1) ? $clog2(TRACE_NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } trace_state_t;

  // Field order is also the bit order used when an entry is viewed as a flat word.
  typedef struct packed {
    logic [TRACE_CH_W-1:0]   ch;
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] data;
    logic [TRACE_CYC_W-1:0]  cycle;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_mem.sv
// Trace entry storage: multi-port write, single asynchronous read.
// Write lands on the clock edge; the read port is combinational from the array.
// No backpressure; the caller guarantees distinct write addresses.
module wb_trace_mem
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  parameter int NPORT = TRACE_NUM_CH
) (
  input  logic                                 clk,
  input  logic [NPORT-1:0]                     we,
  input  logic [NPORT-1:0][$clog2(DEPTH)-1:0]  waddr,
  input  trace_entry_t [NPORT-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0]             raddr,
  output trace_entry_t                         rdata
);

  trace_entry_t mem [DEPTH];

  // Every enabled port writes its own slot; slots never collide.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (we[p]) mem[waddr[p]] <= wdata[p];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: timestamps register-file writes into a circular buffer.
// Entry visible on rd_* one cycle after capture; head is combinational from storage.
// Drain is valid/ready; writes that do not fit are dropped and counted, never stalled.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int NUM_CH = TRACE_NUM_CH,
  parameter int DATA_W = TRACE_DATA_W,
  parameter int ADDR_W = TRACE_ADDR_W,
  parameter int DEPTH  = TRACE_DEPTH,
  parameter int CYC_W  = TRACE_CYC_W
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        capture_en,
  input  logic                                        clear,
  input  logic [CYC_W-1:0]                            cycle_limit,
  input  logic [NUM_CH-1:0]                           wr_en,
  input  logic [NUM_CH*ADDR_W-1:0]                    wr_addr,
  input  logic [NUM_CH*DATA_W-1:0]                    wr_data,
  output logic                                        rd_valid,
  input  logic                                        rd_ready,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
  output logic [ADDR_W-1:0]                           rd_addr,
  output logic [DATA_W-1:0]                           rd_data,
  output logic [CYC_W-1:0]                            rd_cycle,
  output logic [$clog2(DEPTH):0]                      count,
  output logic                                        full,
  output logic                                        overflow,
  output logic [CYC_W-1:0]                            drop_cnt,
  output logic                                        done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  trace_state_t                 state_q, state_d;
  logic [CYC_W-1:0]             cyc_q;
  logic [PTR_W-1:0]             wptr_q, rptr_q;
  logic [CNT_W-1:0]             space, n_req, n_push, n_drop;
  logic [NUM_CH-1:0]            push_en;
  logic [NUM_CH-1:0][PTR_W-1:0] push_idx;
  trace_entry_t [NUM_CH-1:0]    push_ent;
  trace_entry_t                 head;
  logic                         cap, pop, hit_limit;
  logic [CYC_W:0]               drop_sum;

  assign cap       = (state_q == CAPTURE) && capture_en;
  assign hit_limit = cap && (cycle_limit != '0) && (cyc_q == cycle_limit - CYC_W'(1));
  assign rd_valid  = (count != '0);
  assign pop       = rd_valid && rd_ready;
  assign full      = (count == CNT_W'(DEPTH));
  // A same-cycle pop does not make room; space is judged on the registered count.
  assign space     = CNT_W'(DEPTH) - count;
  assign drop_sum  = {1'b0, drop_cnt} + (CYC_W+1)'(n_drop);

  // Rank asserted channels in ascending order; a channel fits if its rank is below the free space.
  always_comb begin
    n_req    = '0;
    n_push   = '0;
    push_en  = '0;
    push_idx = '0;
    push_ent = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      push_en[c]        = cap && wr_en[c] && (n_req < space);
      push_idx[c]       = wptr_q + n_req[PTR_W-1:0];
      push_ent[c].ch    = CH_W'(c);
      push_ent[c].addr  = wr_addr[c*ADDR_W +: ADDR_W];
      push_ent[c].data  = wr_data[c*DATA_W +: DATA_W];
      push_ent[c].cycle = cyc_q;
      if (wr_en[c])   n_req  = n_req + CNT_W'(1);
      if (push_en[c]) n_push = n_push + CNT_W'(1);
    end
    n_drop = cap ? (n_req - n_push) : '0;
  end

  // Capture window control; DONE is left only through clear or reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture_en) state_d = CAPTURE;
      CAPTURE: begin
        if (hit_limit)        state_d = DONE;
        else if (!capture_en) state_d = IDLE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State register; clear behaves like reset for the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Pointers, occupancy, timestamp and drop accounting.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cyc_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      done     <= 1'b0;
    end else begin
      if (cap) cyc_q <= cyc_q + CYC_W'(1);
      wptr_q <= wptr_q + n_push[PTR_W-1:0];
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
      count  <= count + n_push - CNT_W'(pop);
      if (n_drop != '0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[CYC_W] ? '1 : drop_sum[CYC_W-1:0];
      end
      if (hit_limit) done <= 1'b1;
    end
  end

  wb_trace_mem #(
    .DEPTH (DEPTH),
    .NPORT (NUM_CH)
  ) u_mem (
    .clk   (clk),
    .we    (push_en),
    .waddr (push_idx),
    .wdata (push_ent),
    .raddr (rptr_q),
    .rdata (head)
  );

  // Head is forced to zero while empty so the outputs are defined straight out of reset.
  assign rd_ch    = rd_valid ? head.ch    : '0;
  assign rd_addr  = rd_valid ? head.addr  : '0;
  assign rd_data  = rd_valid ? head.data  : '0;
  assign rd_cycle = rd_valid ? head.cycle : '0;

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;
  import wb_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, capture_en, clear, rd_ready;
  logic [15:0] cycle_limit;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rd_valid, full, overflow, done;
  logic [0:0]  rd_ch;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [15:0] rd_cycle, drop_cnt;
  logic [4:0]  count;

  int n_checks = 0;
  int n_fail   = 0;
  int ts;
  trace_entry_t sb_q[$];

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        rdy;
    int          exp_cnt;
  } vec_t;
  vec_t vt[8];

  always #5 clk = ~clk;

  wb_trace_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture_en  (capture_en),
    .clear       (clear),
    .cycle_limit (cycle_limit),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_ch       (rd_ch),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_cycle    (rd_cycle),
    .count       (count),
    .full        (full),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .done        (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] head_bits();
    return 64'({rd_ch, rd_addr, rd_data, rd_cycle});
  endfunction

  task automatic sb_push(input int ch, input logic [4:0] a, input logic [31:0] d, input int t);
    trace_entry_t e;
    e.ch    = TRACE_CH_W'(ch);
    e.addr  = a;
    e.data  = d;
    e.cycle = 16'(t);
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  // One clock: observe a pop mid-low-phase, then return at the next falling edge.
  task automatic cyc();
    #2;
    if (rd_valid && rd_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_pop: pop of 0x%0h with nothing expected", head_bits());
      end else begin
        check("sb_pop", head_bits(), 64'(sb_q[0]));
        sb_q.delete(0);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_head(input string name);
    check({name, "_valid"}, 64'(rd_valid), 64'(sb_q.size() != 0));
    if (sb_q.size() != 0) check(name, head_bits(), 64'(sb_q[0]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'b00, 5'd0, 32'd0,  5'd0, 32'd0,  1'b0, 0};
    vt[1] = '{2'b00, 5'd0, 32'd0,  5'd0, 32'd0,  1'b0, 0};
    vt[2] = '{2'b01, 5'd3, 32'd7,  5'd0, 32'd0,  1'b0, 1};
    vt[3] = '{2'b11, 5'd1, 32'd10, 5'd2, 32'd20, 1'b1, 2};
    vt[4] = '{2'b00, 5'd0, 32'd0,  5'd0, 32'd0,  1'b1, 1};
    vt[5] = '{2'b00, 5'd0, 32'd0,  5'd0, 32'd0,  1'b1, 0};
    vt[6] = '{2'b10, 5'd0, 32'd0,  5'd9, 32'd99, 1'b0, 1};
    vt[7] = '{2'b00, 5'd0, 32'd0,  5'd0, 32'd0,  1'b1, 0};

    rst_n = 1'b0; capture_en = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    cycle_limit = 16'd0;
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    @(negedge clk);
    cyc();
    check("rst_count",    64'(count),    64'd0);
    check("rst_valid",    64'(rd_valid), 64'd0);
    check("rst_full",     64'(full),     64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_head",     head_bits(),   64'd0);

    // Leaving IDLE takes one cycle; the next cycle is capture timestamp 0.
    rst_n = 1'b1; capture_en = 1'b1;
    cyc();

    ts = 0;
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].en, vt[i].a0, vt[i].d0, vt[i].a1, vt[i].d1);
      rd_ready = vt[i].rdy;
      if (vt[i].en[0]) sb_push(0, vt[i].a0, vt[i].d0, ts);
      if (vt[i].en[1]) sb_push(1, vt[i].a1, vt[i].d1, ts);
      cyc();
      ts++;
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].exp_cnt));
      check_head($sformatf("vec%0d_head", i));
    end

    // Fill with both channels: eight cycles fit exactly, the ninth drops both.
    rd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(2'b11, 5'(i), 32'(100 + i), 5'(i + 16), 32'(200 + i));
      if (i < 8) begin
        sb_push(0, 5'(i), 32'(100 + i), ts);
        sb_push(1, 5'(i + 16), 32'(200 + i), ts);
      end
      cyc();
      ts++;
      check($sformatf("fill%0d_count", i), 64'(count), 64'((i < 8) ? 2 * (i + 1) : 16));
      if (i == 7) begin
        check("fill7_full",     64'(full),     64'd1);
        check("fill7_overflow", 64'(overflow), 64'd0);
      end
    end
    check("fill_full",     64'(full),     64'd1);
    check("fill_overflow", 64'(overflow), 64'd1);
    check("fill_drop_cnt", 64'(drop_cnt), 64'd2);

    // Pop while full frees no space this cycle: the push is dropped.
    drive(2'b01, 5'd30, 32'hABCD, 5'd0, 32'd0);
    rd_ready = 1'b1;
    cyc();
    ts++;
    check("popfull_count", 64'(count),    64'd15);
    check("popfull_drop",  64'(drop_cnt), 64'd3);
    rd_ready = 1'b0;
    drive(2'b01, 5'd31, 32'h1234, 5'd0, 32'd0);
    sb_push(0, 5'd31, 32'h1234, ts);
    cyc();
    ts++;
    check("refill_count", 64'(count),    64'd16);
    check("refill_drop",  64'(drop_cnt), 64'd3);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) cyc();
    check("drain_count", 64'(count),       64'd0);
    check("drain_sb",    64'(sb_q.size()), 64'd0);

    // Capture window of five cycles.
    rd_ready = 1'b0; clear = 1'b1; cycle_limit = 16'd5;
    cyc();
    check("clr_count",    64'(count),    64'd0);
    check("clr_overflow", 64'(overflow), 64'd0);
    check("clr_drop_cnt", 64'(drop_cnt), 64'd0);
    check("clr_done",     64'(done),     64'd0);
    clear = 1'b0;
    cyc();
    ts = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || i == 4) begin
        drive(2'b01, 5'(i + 1), 32'(500 + i), 5'd0, 32'd0);
        sb_push(0, 5'(i + 1), 32'(500 + i), ts);
      end else begin
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      end
      cyc();
      ts++;
      if (i == 3) check("lim_done_early", 64'(done), 64'd0);
    end
    check("lim_done",  64'(done),  64'd1);
    check("lim_count", 64'(count), 64'd2);
    drive(2'b01, 5'd7, 32'd777, 5'd0, 32'd0);
    cyc();
    check("lim_nocap_count", 64'(count), 64'd2);
    check("lim_done_hold",   64'(done),  64'd1);
    check_head("lim_head");
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    clear = 1'b1;
    cyc();
    sb_q.delete();
    check("lim_clr_done",  64'(done),     64'd0);
    check("lim_clr_count", 64'(count),    64'd0);
    check("lim_clr_valid", 64'(rd_valid), 64'd0);
    clear = 1'b0; cycle_limit = 16'd0;
    cyc();

    // Reset in the middle of a capture with six entries held.
    ts = 0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 5'(i + 2), 32'(900 + i), 5'(i + 12), 32'(950 + i));
      sb_push(0, 5'(i + 2), 32'(900 + i), ts);
      sb_push(1, 5'(i + 12), 32'(950 + i), ts);
      cyc();
      ts++;
    end
    check("pre_rst_count", 64'(count), 64'd6);
    check_head("pre_rst_head");
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    rst_n = 1'b0;
    cyc();
    sb_q.delete();
    check("mid_rst_count",    64'(count),    64'd0);
    check("mid_rst_valid",    64'(rd_valid), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    check("mid_rst_head",     head_bits(),   64'd0);
    rst_n = 1'b1;
    drive(2'b01, 5'd5, 32'd55, 5'd0, 32'd0);
    cyc();
    check("post_rst_idle_count", 64'(count), 64'd0);
    drive(2'b01, 5'd6, 32'd66, 5'd0, 32'd0);
    sb_push(0, 5'd6, 32'd66, 0);
    cyc();
    check("post_rst_count", 64'(count), 64'd1);
    check_head("post_rst_head");
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    rd_ready = 1'b1;
    cyc();
    check("post_rst_drain", 64'(count),       64'd0);
    check("post_rst_sb",    64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
Synthesisable writeback trace capture for cpu_top: records every register-file write from NUM_CH writeback channels (channel 0 = general regs, channel 1 = b-regs) with a cycle timestamp into a circular buffer. Entries are drained through a valid/ready port to a debug/UART path, replacing simulation-only $display tracing. It adds a capture window, a cycle limit, and overflow accounting.

Parameters:
NUM_CH, 2, number of writeback channels sampled per cycle
DATA_W, 32, write data width
ADDR_W, 5, register address width
DEPTH, 16, buffer entries (power of 2, >= NUM_CH)
CYC_W, 16, timestamp/cycle counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
capture_en  in  1  level; capture while high
clear  in  1  synchronous clear of buffer, counters, flags
cycle_limit  in  CYC_W  capture window length in cycles; 0 = unlimited
wr_en  in  NUM_CH  per-channel write strobe
wr_addr  in  NUM_CH*ADDR_W  per-channel dest address, channel c at [c*ADDR_W +: ADDR_W]
wr_data  in  NUM_CH*DATA_W  per-channel write data, same packing
rd_valid  out  1  head entry available
rd_ready  in  1  consumer accepts head
rd_ch  out  $clog2(NUM_CH) (min 1)  head channel index
rd_addr  out  ADDR_W  head register address
rd_data  out  DATA_W  head write data
rd_cycle  out  CYC_W  head timestamp
count  out  $clog2(DEPTH)+1  occupancy
full  out  1  count == DEPTH
overflow  out  1  sticky: at least one write dropped
drop_cnt  out  CYC_W  dropped writes, saturating
done  out  1  sticky: cycle_limit reached

Behaviour:
- Reset (rst_n low at posedge) and clear: all pointers 0, count 0, rd_valid 0, overflow 0, drop_cnt 0, done 0, cycle counter 0. rst_n has priority over clear; a reset mid-capture discards all contents.
- States: IDLE, CAPTURE, DONE. IDLE->CAPTURE when capture_en=1. CAPTURE->IDLE when capture_en=0 (counter holds). CAPTURE->DONE when cycle_limit!=0 and counter == cycle_limit-1 on a capture cycle; done set that cycle. DONE exits only via clear/reset. Drain works in every state.
- Cycle counter: increments each CAPTURE cycle and wraps at 2^CYC_W. An entry's timestamp is the counter value in the cycle its wr_en is sampled. The first capture cycle has timestamp 0.
- Capture occurs only in CAPTURE, including the final cycle that enters DONE. All asserted channels are pushed in the same cycle in ascending channel order at consecutive slots.
- Space for pushes in a cycle = DEPTH - count at the start of that cycle. A pop in the same cycle frees a slot only for the next cycle.
- If asserted channels exceed space: the lowest-index channels that fit are written. The rest are dropped, overflow is set, and drop_cnt += dropped, saturating at all-ones.
- Read: rd_valid = (count != 0). rd_* show the head entry combinationally from storage and are stable while rd_valid && !rd_ready. A pop occurs on rd_valid && rd_ready. rd_* are don't-care when rd_valid is 0, but are driven 0 after reset.
- count next = count + pushes - pop. Pointers wrap modulo DEPTH.
- Zero-latency path excluded: an entry is visible on rd_* the cycle after it is pushed.

Decomposition:
- Package wb_trace_pkg: typedef struct trace_entry_t {ch, addr, data, cycle}, widths derived from the package-level defaults, state enum trace_state_t {IDLE, CAPTURE, DONE}.
- Sub-module wb_trace_mem: DEPTH x entry storage with NUM_CH write ports (consecutive addresses) and one asynchronous read port. Top holds the FSM, pointers, counters and the push/drop computation.

Test Plan:
- Reset, then capture_en=1; ch0 writes addr 3 data 7 at capture cycle 2 -> next cycle rd_valid=1, rd_ch=0, rd_addr=3, rd_data=7, rd_cycle=2; count 1.
- Both channels in one cycle: ch0 (1,10), ch1 (2,20) with rd_ready=1 -> pops are ch0 then ch1 in consecutive cycles with equal rd_cycle.
- DEPTH=16, rd_ready=0, both channels every cycle for 9 cycles -> count 16, full=1, overflow=1, drop_cnt=2. The 8th cycle writes both channels (count reaches 16); the 9th cycle drops both.
- cycle_limit=5 with capture_en held high -> done=1 after 5 capture cycles; writes at a later cycle are not captured; clear -> done=0, count=0.
- Full buffer, pop and 1 push in the same cycle -> push dropped, drop_cnt+1, count 15. Next cycle's push is accepted.
- rst_n=0 for one cycle mid-capture with count=6 -> count=0, rd_valid=0, overflow=0, FSM IDLE. Capture resumes with timestamp 0.
